// File: rtl/z80_sys_pkg.sv
// Shared types and sizing helpers for the Z80 system bus arbiter.
// Counter widths are derived from burst/slice lengths so a count of N fits.
package z80_sys_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    GRANT     = 3'd2,
    RELEASE   = 3'd3,
    CPU_SLICE = 3'd4
  } arb_state_t;

  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_MIN_CPU   = 4;
  localparam int BURST_CNT_W   = $clog2(DEF_MAX_BURST + 1);
  localparam int SLICE_CNT_W   = $clog2(DEF_MIN_CPU + 1);

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Zero latency; o_win is all-zero when no request is pending.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_win,
  output logic [IDX_W-1:0] o_idx
);

  logic [NREQ-1:0] w_rot;

  // Rotate so bit 0 is the requester at ptr; the search then runs low to high.
  assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    logic found;
    int   sel;
    int   idx;
    found = 1'b0;
    sel   = 0;
    idx   = 0;
    o_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && w_rot[i]) begin
        found = 1'b1;
        sel   = i;
      end
    end
    idx = int'(i_ptr) + sel;
    if (idx >= NREQ) idx = idx - NREQ;
    o_idx = IDX_W'(idx);
    for (int k = 0; k < NREQ; k++) begin
      o_win[k] = found && (idx == k);
    end
  end

endmodule

// File: rtl/z80_dma_arbiter.sv
// Hands the Z80 bus to DMA requesters round-robin via nBUSRQ/nBUSACK, one tenure at a time.
// Registered outputs; req to nBUSRQ low in 1 clock, registered ack to gnt in 1 clock.
module z80_dma_arbiter
  import z80_sys_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int MIN_CPU   = DEF_MIN_CPU
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic            nBUSRQ,
  input  logic            nBUSACK,
  output logic            bus_own,
  output logic            burst_timeout,
  output logic            busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW    = (MAX_BURST == DEF_MAX_BURST) ? BURST_CNT_W : cnt_w(MAX_BURST);
  localparam int SW    = (MIN_CPU == DEF_MIN_CPU) ? SLICE_CNT_W : cnt_w(MIN_CPU);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic             r_ack;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_w_idx;
  logic [BW-1:0]    r_burst;
  logic [SW-1:0]    r_slice;
  logic [NREQ-1:0]  r_gnt;
  logic             r_nbusrq;
  logic             r_bus_own;
  logic             r_timeout;
  logic             r_busy;

  logic [NREQ-1:0]  w_pick_win;
  logic [IDX_W-1:0] w_pick_idx;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic             w_timeout;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_win (w_pick_win),
    .o_idx (w_pick_idx)
  );

  assign w_ptr_nxt = (int'(r_w_idx) == NREQ - 1) ? '0 : r_w_idx + IDX_W'(1);

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_gnt_nxt = '0;
    unique case (r_state)
      IDLE: begin
        if (|req) w_next = REQ;
      end
      REQ: begin
        if (r_ack && (|req))   w_next = GRANT;
        else if (!(|req))      w_next = r_ack ? RELEASE : IDLE;
      end
      GRANT: begin
        // Lost acknowledge and done both beat the burst limit, so no timeout pulse.
        if (!r_ack)                                 w_next = RELEASE;
        else if (done[r_w_idx] || !req[r_w_idx])    w_next = RELEASE;
        else if (int'(r_burst) == MAX_BURST - 1) begin
          w_next    = RELEASE;
          w_timeout = 1'b1;
        end
      end
      RELEASE: begin
        if (!r_ack) w_next = (MIN_CPU > 0) ? CPU_SLICE : IDLE;
      end
      CPU_SLICE: begin
        if (int'(r_slice) >= MIN_CPU - 1) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_next == GRANT) w_gnt_nxt = (r_state == GRANT) ? r_gnt : w_pick_win;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ack     <= 1'b0;
      r_ptr     <= '0;
      r_w_idx   <= '0;
      r_burst   <= '0;
      r_slice   <= '0;
      r_gnt     <= '0;
      r_nbusrq  <= 1'b1;
      r_bus_own <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ack     <= ~nBUSACK;
      r_state   <= w_next;
      r_burst   <= (r_state == GRANT && w_next == GRANT) ? r_burst + BW'(1) : '0;
      r_slice   <= (r_state == CPU_SLICE && w_next == CPU_SLICE) ? r_slice + SW'(1) : '0;
      if (r_state == REQ && w_next == GRANT)   r_w_idx <= w_pick_idx;
      if (r_state == GRANT && w_next != GRANT) r_ptr   <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_nbusrq  <= !(w_next == REQ || w_next == GRANT);
      r_bus_own <= (w_next == GRANT);
      r_timeout <= w_timeout;
      r_busy    <= (w_next != IDLE);
    end
  end

  assign gnt           = r_gnt;
  assign nBUSRQ        = r_nbusrq;
  assign bus_own       = r_bus_own;
  assign burst_timeout = r_timeout;
  assign busy          = r_busy;

endmodule

// File: tb/tb_z80_dma_arbiter.sv
// Scoreboard bench: expected tenures queued by stimulus, checked by a monitor as gnt drops.
module tb_z80_dma_arbiter;

  localparam int NREQ      = 2;
  localparam int MAX_BURST = 16;
  localparam int MIN_CPU   = 4;
  localparam int ACK_DLY   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] done;
  logic [1:0] gnt;
  logic       nBUSRQ;
  logic       nBUSACK;
  logic       bus_own;
  logic       burst_timeout;
  logic       busy;

  typedef struct {
    logic [1:0] g;
    int         len;
    logic       tmo;
  } ten_t;

  ten_t exp_q[$];
  int   obs_gap[$];
  int   total = 0;
  int   bad = 0;
  int   done_at[2];
  bit   cpu_en = 1'b1;
  bit   mon_en = 1'b0;
  bit   gap_en = 1'b0;
  int   exp_tmo_total = 0;
  int   tmo_cycles = 0;
  int   inv_bad = 0;

  always #5 clk = ~clk;

  z80_dma_arbiter #(
    .NREQ      (NREQ),
    .MAX_BURST (MAX_BURST),
    .MIN_CPU   (MIN_CPU)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .done          (done),
    .gnt           (gnt),
    .nBUSRQ        (nBUSRQ),
    .nBUSACK       (nBUSACK),
    .bus_own       (bus_own),
    .burst_timeout (burst_timeout),
    .busy          (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_ten(input logic [1:0] g, input int len, input logic tmo);
    ten_t t;
    t.g   = g;
    t.len = len;
    t.tmo = tmo;
    exp_q.push_back(t);
    if (tmo) exp_tmo_total++;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check_val({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check_val({tag, "_idle"}, {31'd0, busy}, 0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req        = 2'b00;
    done_at[0] = 0;
    done_at[1] = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // CPU: grants the bus ACK_DLY clocks after nBUSRQ falls, releases as soon as it rises.
  initial begin : cpu_model
    int ack_cnt;
    ack_cnt = 0;
    nBUSACK = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!cpu_en || nBUSRQ !== 1'b0) begin
        ack_cnt = 0;
        nBUSACK = 1'b1;
      end else begin
        ack_cnt++;
        if (ack_cnt >= ACK_DLY) nBUSACK = 1'b0;
      end
    end
  end

  // Requesters: pulse done on the done_at-th clock of their own grant (0 = never).
  initial begin : req_model
    int cnt[2];
    cnt[0] = 0;
    cnt[1] = 0;
    done   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (gnt[i] === 1'b1) cnt[i]++;
        else cnt[i] = 0;
        done[i] = (done_at[i] != 0) && (cnt[i] == done_at[i]);
      end
    end
  end

  initial begin : monitor
    logic [1:0] cur_g;
    int         cur_len;
    logic       prev_ackn;
    int         gap;
    bit         gap_run;
    ten_t       e;
    cur_g     = 2'b00;
    cur_len   = 0;
    prev_ackn = 1'b1;
    gap       = 0;
    gap_run   = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus_own !== (|gnt)) inv_bad++;
        if ($countones(gnt) > 1) inv_bad++;
        if (burst_timeout === 1'b1) tmo_cycles++;
        if (gnt !== 2'b00) begin
          if (cur_len == 0) cur_g = gnt;
          else if (gnt !== cur_g) inv_bad++;
          cur_len++;
        end else if (cur_len != 0) begin
          if (exp_q.size() == 0) begin
            check_val("ten_unexpected", {30'd0, cur_g}, 0);
          end else begin
            e = exp_q.pop_front();
            check_val("ten_gnt", {30'd0, cur_g}, {30'd0, e.g});
            check_val("ten_len", cur_len, e.len);
            check_val("ten_tmo", {31'd0, burst_timeout}, {31'd0, e.tmo});
          end
          cur_len = 0;
        end
        if (reset) gap_run = 1'b0;
        if (nBUSACK === 1'b1 && prev_ackn === 1'b0) begin
          gap_run = 1'b1;
          gap     = 0;
        end
        if (gap_run) begin
          if (nBUSRQ === 1'b0) begin
            gap_run = 1'b0;
            if (gap_en) obs_gap.push_back(gap);
          end else begin
            gap++;
          end
        end
        prev_ackn = nBUSACK;
      end
    end
  end

  initial begin : stim
    int n;
    reset = 1'b1;
    req   = 2'b00;
    done_at[0] = 0;
    done_at[1] = 0;
    do_reset();
    mon_en = 1'b1;

    check_val("rst_gnt", {30'd0, gnt}, 0);
    check_val("rst_nbusrq", {31'd0, nBUSRQ}, 1);
    check_val("rst_bus_own", {31'd0, bus_own}, 0);
    check_val("rst_timeout", {31'd0, burst_timeout}, 0);
    check_val("rst_busy", {31'd0, busy}, 0);

    // Basic grant with done on the 5th grant clock.
    done_at[0] = 5;
    push_ten(2'b01, 5, 1'b0);
    req = 2'b01;
    tick();
    check_val("basic_rq_low", {31'd0, nBUSRQ}, 0);
    n = 0;
    while (nBUSACK !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check_val("basic_ack_seen", {31'd0, nBUSACK}, 0);
    tick();
    check_val("basic_gnt_early", {30'd0, gnt}, 0);
    tick();
    check_val("basic_gnt", {30'd0, gnt}, 2'b01);
    n = 0;
    while (gnt !== 2'b00 && n < 40) begin
      tick();
      n++;
    end
    check_val("basic_rq_rel", {31'd0, nBUSRQ}, 1);
    req = 2'b00;
    wait_drain("basic");
    wait_idle("basic");

    // Round-robin with both requesting, CPU slice between tenures.
    do_reset();
    gap_en     = 1'b1;
    done_at[0] = 2;
    done_at[1] = 2;
    push_ten(2'b01, 2, 1'b0);
    push_ten(2'b10, 2, 1'b0);
    push_ten(2'b01, 2, 1'b0);
    push_ten(2'b10, 2, 1'b0);
    req = 2'b11;
    wait_drain("rr");
    req = 2'b00;
    wait_idle("rr");
    gap_en = 1'b0;
    check_val("rr_gap_n", obs_gap.size(), 3);
    // ack sync + RELEASE decision + MIN_CPU slice + one IDLE clock
    for (int i = 0; i < obs_gap.size(); i++) check_val("rr_gap", obs_gap[i], MIN_CPU + 3);

    // Burst timeout, rotating to requester 1, then back to 0 when alone.
    do_reset();
    push_ten(2'b01, MAX_BURST, 1'b1);
    push_ten(2'b10, MAX_BURST, 1'b1);
    req = 2'b11;
    wait_drain("tmo_rr");
    req = 2'b00;
    wait_idle("tmo_rr");
    push_ten(2'b01, MAX_BURST, 1'b1);
    push_ten(2'b01, MAX_BURST, 1'b1);
    req = 2'b01;
    wait_drain("tmo_same");
    req = 2'b00;
    wait_idle("tmo_same");

    // done on the last allowed clock wins over the timeout.
    do_reset();
    done_at[0] = MAX_BURST;
    push_ten(2'b01, MAX_BURST, 1'b0);
    req = 2'b01;
    wait_drain("simul");
    req = 2'b00;
    wait_idle("simul");

    // Abandon before the CPU acknowledges.
    do_reset();
    cpu_en = 1'b0;
    req = 2'b01;
    tick();
    check_val("abort_rq_low", {31'd0, nBUSRQ}, 0);
    tick();
    req = 2'b00;
    tick();
    check_val("abort_rq_rel", {31'd0, nBUSRQ}, 1);
    check_val("abort_busy", {31'd0, busy}, 0);
    check_val("abort_gnt", {30'd0, gnt}, 0);
    cpu_en = 1'b1;
    tick();

    // Reset in the middle of a grant to requester 1.
    do_reset();
    push_ten(2'b10, 4, 1'b0);
    req = 2'b10;
    n = 0;
    while (gnt !== 2'b10 && n < 40) begin
      tick();
      n++;
    end
    check_val("rst_mid_gnt_seen", {30'd0, gnt}, 2'b10);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_val("rst_mid_gnt", {30'd0, gnt}, 0);
    check_val("rst_mid_bus_own", {31'd0, bus_own}, 0);
    check_val("rst_mid_nbusrq", {31'd0, nBUSRQ}, 1);
    check_val("rst_mid_busy", {31'd0, busy}, 0);
    check_val("rst_mid_timeout", {31'd0, burst_timeout}, 0);
    reset      = 1'b0;
    done_at[0] = 3;
    done_at[1] = 3;
    push_ten(2'b01, 3, 1'b0);
    req = 2'b11;
    wait_drain("rst_after");
    req = 2'b00;
    wait_idle("rst_after");

    check_val("tmo_cycles", tmo_cycles, exp_tmo_total);
    check_val("invariants", inv_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
